// File: rtl/spi_sub_bus.sv
// SPI mode-0 peripheral to register-bus bridge for N_SLAVES register slaves.
// The SPI pins are oversampled in the i_clk domain. The first word of a
// transaction is a command: R/W bit, slave index and register address.
// Data words follow as a burst, and the register address auto-increments.
module spi_sub_bus #(
  parameter int N_SLAVES    = 4,
  parameter int REG_AW      = 5,
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_sck,
  input  logic                     i_spi_si,
  output logic                     o_spi_so,
  output logic                     o_spi_so_oe,
  output logic [REG_AW-1:0]        o_reg_addr,
  output logic [DW-1:0]            o_data_wr,
  output logic                     o_wr_req,
  output logic                     o_rd_ack,
  output logic [N_SLAVES-1:0]      o_slave_sel,
  input  logic [N_SLAVES*DW-1:0]   i_slave_rdata,
  output logic                     o_busy
);

  localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = $clog2(DW);

  if (SEL_W + REG_AW > DW - 1) begin : g_bad_width
    $error("spi_sub_bus: select and address fields do not fit below the R/W bit");
  end
  if (N_SLAVES < 1 || N_SLAVES > 16) begin : g_bad_slaves
    $error("spi_sub_bus: N_SLAVES must be 1..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("spi_sub_bus: SYNC_STAGES must be 2..3");
  end

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR, S_RD} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, sck_sync, si_sync, fill;
  logic                   cs_prev, sck_prev, armed;
  logic                   cs_s, sck_s, si_s;
  logic                   sck_rise, sck_fall, cs_fall;

  state_t                 state;
  logic [DW-1:0]          rx_sh, tx_sh, rx_next, rd_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   word_done;
  logic [SEL_W-1:0]       sel_idx, cmd_sel;
  logic [N_SLAVES-1:0]    cmd_oh;
  logic                   in_range, load_pend, inc_pend;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign si_s     = si_sync[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev;
  assign sck_fall = ~sck_s &  sck_prev;
  assign cs_fall  =  cs_prev & ~cs_s;

  // Synchronise the SPI pins and keep the previous samples for edge detection.
  // The bridge is armed only after it has seen a real CS-high sample, so a CS
  // that is already low when reset is released does not start a transfer.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      si_sync  <= '0;
      fill     <= '0;
      cs_prev  <= 1'b1;
      sck_prev <= 1'b0;
      armed    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs_n};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      si_sync  <= {si_sync[SYNC_STAGES-2:0], i_spi_si};
      fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
      cs_prev  <= cs_s;
      sck_prev <= sck_s;
      armed    <= armed | (fill[SYNC_STAGES-1] & cs_s);
    end
  end

  assign rx_next   = {rx_sh[DW-2:0], si_s};
  assign word_done = (bit_cnt == CNT_W'(DW - 1));
  assign cmd_sel   = rx_next[REG_AW +: SEL_W];
  assign o_spi_so  = tx_sh[DW-1];

  // Decode the command slave index to a one-hot select. Out-of-range indices give zero.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    cmd_oh = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (cmd_sel == SEL_W'(k)) cmd_oh[k] = 1'b1;
    end
  end

  // Select the read word of the latched slave. Out-of-range slaves read as all-ones.
  always_comb begin
    rd_word = '1;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (sel_idx == SEL_W'(k)) rd_word = i_slave_rdata[k*DW +: DW];
    end
  end

  // Transaction FSM: command decode, write/read bursts, address increment, abort.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      rx_sh       <= '0;
      tx_sh       <= '0;
      bit_cnt     <= '0;
      sel_idx     <= '0;
      in_range    <= 1'b0;
      load_pend   <= 1'b0;
      inc_pend    <= 1'b0;
      o_reg_addr  <= '0;
      o_data_wr   <= '0;
      o_wr_req    <= 1'b0;
      o_rd_ack    <= 1'b0;
      o_slave_sel <= '0;
      o_busy      <= 1'b0;
      o_spi_so_oe <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults; a later assignment in this block overrides them.
      o_wr_req    <= 1'b0;
      o_rd_ack    <= 1'b0;
      o_spi_so_oe <= armed & ~cs_s;
      if (inc_pend) begin
        o_reg_addr <= o_reg_addr + REG_AW'(1);
        inc_pend   <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (armed && cs_fall) begin
            state   <= S_CMD;
            o_busy  <= 1'b1;
            bit_cnt <= '0;
            rx_sh   <= '0;
          end
        end
        default: begin
          if (cs_s) begin
            // CS has risen. Drop any partial word. This takes priority over a
            // simultaneous SCK edge.
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_slave_sel <= '0;
            tx_sh       <= '0;
            bit_cnt     <= '0;
            load_pend   <= 1'b0;
            inc_pend    <= 1'b0;
          end else begin
            if (sck_rise) begin
              rx_sh   <= rx_next;
              bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
              if (word_done) begin
                case (state)
                  S_CMD: begin
                    state       <= rx_next[DW-1] ? S_RD : S_WR;
                    o_reg_addr  <= rx_next[REG_AW-1:0];
                    sel_idx     <= cmd_sel;
                    in_range    <= |cmd_oh;
                    o_slave_sel <= cmd_oh;
                    load_pend   <= rx_next[DW-1];
                  end
                  S_WR: begin
                    o_data_wr <= rx_next;
                    o_wr_req  <= in_range;
                    inc_pend  <= 1'b1;
                  end
                  S_RD:    load_pend <= 1'b1;
                  default: ;
                endcase
              end
            end
            if (sck_fall && state == S_RD) begin
              if (load_pend) begin
                tx_sh     <= rd_word;
                o_rd_ack  <= in_range;
                load_pend <= 1'b0;
                inc_pend  <= 1'b1;
              end else begin
                tx_sh <= tx_sh << 1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sub_bus.sv
// Directed bench for spi_sub_bus. It uses three instances: the default 4-slave
// build, a 3-slave build for out-of-range access, and an 8-slave/4-bit-address build.
module tb_spi_sub_bus;

  logic clk = 1'b0;
  logic rst;
  logic sck, si;
  logic cs4, cs3, cs8;
  int   cur;
  int   total = 0;
  int   bad   = 0;

  logic        so4, oe4, wr4, ack4, busy4;
  logic [4:0]  addr4;
  logic [7:0]  dwr4;
  logic [3:0]  sel4;
  logic [31:0] rdata4;

  logic        so3, oe3, wr3, ack3, busy3;
  logic [4:0]  addr3;
  logic [7:0]  dwr3;
  logic [2:0]  sel3;
  logic [23:0] rdata3;

  logic        so8, oe8, wr8, ack8, busy8;
  logic [3:0]  addr8;
  logic [7:0]  dwr8;
  logic [7:0]  sel8;
  logic [63:0] rdata8;

  logic        so_mux;
  logic [12:0] wr_log4[$];
  logic [4:0]  ack_log4[$];
  logic [11:0] wr_log8[$];
  int          n_wr3, n_ack3;

  always #5 clk = ~clk;

  spi_sub_bus u4 (
    .i_clk(clk), .i_reset(rst), .i_spi_cs_n(cs4), .i_spi_sck(sck), .i_spi_si(si),
    .o_spi_so(so4), .o_spi_so_oe(oe4), .o_reg_addr(addr4), .o_data_wr(dwr4),
    .o_wr_req(wr4), .o_rd_ack(ack4), .o_slave_sel(sel4), .i_slave_rdata(rdata4),
    .o_busy(busy4)
  );

  spi_sub_bus #(.N_SLAVES(3)) u3 (
    .i_clk(clk), .i_reset(rst), .i_spi_cs_n(cs3), .i_spi_sck(sck), .i_spi_si(si),
    .o_spi_so(so3), .o_spi_so_oe(oe3), .o_reg_addr(addr3), .o_data_wr(dwr3),
    .o_wr_req(wr3), .o_rd_ack(ack3), .o_slave_sel(sel3), .i_slave_rdata(rdata3),
    .o_busy(busy3)
  );

  spi_sub_bus #(.N_SLAVES(8), .REG_AW(4)) u8 (
    .i_clk(clk), .i_reset(rst), .i_spi_cs_n(cs8), .i_spi_sck(sck), .i_spi_si(si),
    .o_spi_so(so8), .o_spi_so_oe(oe8), .o_reg_addr(addr8), .o_data_wr(dwr8),
    .o_wr_req(wr8), .o_rd_ack(ack8), .o_slave_sel(sel8), .i_slave_rdata(rdata8),
    .o_busy(busy8)
  );

  // Slave 0 of u4 holds known values at registers 31, 0 and 1. The other slaves return constants.
  always_comb begin
    rdata4 = 32'h4433_2200;
    case (addr4)
      5'd31:   rdata4[7:0] = 8'h3C;
      5'd0:    rdata4[7:0] = 8'h5A;
      5'd1:    rdata4[7:0] = 8'h77;
      default: rdata4[7:0] = 8'h00;
    endcase
  end
  assign rdata3 = 24'h12_34_56;
  assign rdata8 = 64'h0123_4567_89AB_CDEF;
  assign so_mux = (cur == 0) ? so4 : (cur == 1) ? so3 : so8;

  // Log strobes away from the active clock edge.
  always @(negedge clk) begin
    if (wr4)  wr_log4.push_back({addr4, dwr4});
    if (ack4) ack_log4.push_back(addr4);
    if (wr8)  wr_log8.push_back({addr8, dwr8});
    if (wr3)  n_wr3++;
    if (ack3) n_ack3++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic half();
    repeat (6) @(negedge clk);
  endtask

  task automatic set_cs(input logic v);
    case (cur)
      0:       cs4 = v;
      1:       cs3 = v;
      default: cs8 = v;
    endcase
  endtask

  task automatic clear_logs();
    wr_log4.delete();
    ack_log4.delete();
    wr_log8.delete();
    n_wr3  = 0;
    n_ack3 = 0;
  endtask

  task automatic start_cs();
    set_cs(1'b0);
    half();
  endtask

  // Shift n bits MSB first and capture MISO just before each rise.
  // end_mode 1: CS rises together with the final fall.
  // end_mode 2: CS rises together with the final rise.
  task automatic spi_bits(input logic [7:0] v, input int n, input int end_mode,
                          output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      si = v[7-i];
      half();
      rx = {rx[6:0], so_mux};
      if (end_mode == 2 && i == n - 1) begin
        sck = 1'b1;
        set_cs(1'b1);
        half();
        sck = 1'b0;
        half();
      end else begin
        sck = 1'b1;
        half();
        sck = 1'b0;
        if (end_mode == 1 && i == n - 1) set_cs(1'b1);
      end
    end
  endtask

  initial begin
    logic [7:0] rx;
    rst = 1'b1; sck = 1'b0; si = 1'b0;
    cs4 = 1'b1; cs3 = 1'b1; cs8 = 1'b1;
    cur = 0;
    n_wr3 = 0; n_ack3 = 0;
    repeat (4) @(negedge clk);
    check("rst_outputs", {so4, oe4, addr4, dwr4, wr4, ack4, sel4, busy4}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("idle_busy", busy4, 1'b0);

    // Write burst: slave 2, registers 5 and 6.
    clear_logs();
    cur = 0;
    start_cs();
    spi_bits(8'h45, 8, 0, rx);
    check("wr_cmd_miso", rx, 8'h00);
    check("wr_sel", sel4, 4'b0100);
    check("wr_addr0", addr4, 5'd5);
    check("wr_busy", busy4, 1'b1);
    check("wr_oe", oe4, 1'b1);
    spi_bits(8'hA1, 8, 0, rx);
    spi_bits(8'hB2, 8, 1, rx);
    repeat (10) @(negedge clk);
    check("wr_count", wr_log4.size(), 2);
    if (wr_log4.size() == 2) begin
      check("wr_beat0", wr_log4[0], {5'd5, 8'hA1});
      check("wr_beat1", wr_log4[1], {5'd6, 8'hB2});
    end
    check("wr_no_ack", ack_log4.size(), 0);
    check("wr_addr_end", addr4, 5'd7);
    check("wr_end_busy_sel", {busy4, sel4, oe4}, 6'd0);

    // Read burst from slave 0, register 31, wrapping to 0 and 1.
    clear_logs();
    start_cs();
    spi_bits(8'h9F, 8, 0, rx);
    check("rd_sel", sel4, 4'b0001);
    spi_bits(8'h00, 8, 0, rx);
    check("rd_word0", rx, 8'h3C);
    spi_bits(8'h00, 8, 0, rx);
    check("rd_word1", rx, 8'h5A);
    spi_bits(8'h00, 8, 1, rx);
    check("rd_word2", rx, 8'h77);
    repeat (10) @(negedge clk);
    check("rd_ack_count", ack_log4.size(), 3);
    if (ack_log4.size() == 3) begin
      check("rd_ack_addr0", ack_log4[0], 5'd31);
      check("rd_ack_addr1", ack_log4[1], 5'd0);
      check("rd_ack_addr2", ack_log4[2], 5'd1);
    end
    check("rd_no_wr", wr_log4.size(), 0);
    check("rd_addr_end", addr4, 5'd2);
    check("rd_end_miso", so4, 1'b0);

    // Out-of-range slave on the 3-slave build.
    clear_logs();
    cur = 1;
    start_cs();
    spi_bits(8'hE0, 8, 0, rx);
    check("oor_rd_sel", sel3, 3'b000);
    check("oor_rd_busy", busy3, 1'b1);
    spi_bits(8'h00, 8, 1, rx);
    check("oor_rd_data", rx, 8'hFF);
    repeat (10) @(negedge clk);
    start_cs();
    spi_bits(8'h60, 8, 0, rx);
    check("oor_wr_sel", sel3, 3'b000);
    spi_bits(8'h55, 8, 1, rx);
    repeat (10) @(negedge clk);
    check("oor_no_wr", n_wr3, 0);
    check("oor_no_ack", n_ack3, 0);

    // Abort after 5 data bits, then a clean transaction.
    clear_logs();
    cur = 0;
    start_cs();
    spi_bits(8'h21, 8, 0, rx);
    check("abort_sel", sel4, 4'b0010);
    spi_bits(8'hFF, 5, 0, rx);
    half();
    set_cs(1'b1);
    repeat (10) @(negedge clk);
    check("abort_no_wr", wr_log4.size(), 0);
    check("abort_busy_sel", {busy4, sel4}, 5'd0);
    start_cs();
    spi_bits(8'h3E, 8, 0, rx);
    spi_bits(8'hC3, 8, 1, rx);
    repeat (10) @(negedge clk);
    check("after_abort_count", wr_log4.size(), 1);
    if (wr_log4.size() == 1) check("after_abort_beat", wr_log4[0], {5'd30, 8'hC3});

    // CS rises together with the final SCK rise of a data word, so the word is dropped.
    clear_logs();
    start_cs();
    spi_bits(8'h43, 8, 0, rx);
    spi_bits(8'h99, 8, 2, rx);
    repeat (10) @(negedge clk);
    check("cs_wins_no_wr", wr_log4.size(), 0);
    check("cs_wins_busy", busy4, 1'b0);

    // Reset during the second data word of a read burst.
    clear_logs();
    start_cs();
    spi_bits(8'h9F, 8, 0, rx);
    spi_bits(8'h00, 8, 0, rx);
    spi_bits(8'h00, 3, 0, rx);
    check("pre_reset_busy", busy4, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_reset_outputs", {so4, oe4, addr4, dwr4, wr4, ack4, sel4, busy4}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    spi_bits(8'h45, 8, 0, rx);
    spi_bits(8'h12, 8, 0, rx);
    check("post_reset_idle", {busy4, oe4, sel4}, 6'd0);
    check("post_reset_no_wr", wr_log4.size(), 0);
    set_cs(1'b1);
    half();
    half();
    start_cs();
    spi_bits(8'h45, 8, 0, rx);
    spi_bits(8'h5E, 8, 1, rx);
    repeat (10) @(negedge clk);
    check("post_reset_count", wr_log4.size(), 1);
    if (wr_log4.size() == 1) check("post_reset_beat", wr_log4[0], {5'd5, 8'h5E});

    // 8-slave build with 4-bit register address: slave 7, register 10.
    clear_logs();
    cur = 2;
    start_cs();
    spi_bits(8'h7A, 8, 0, rx);
    check("p8_sel", sel8, 8'h80);
    check("p8_addr", addr8, 4'd10);
    spi_bits(8'h0F, 8, 1, rx);
    repeat (10) @(negedge clk);
    check("p8_count", wr_log8.size(), 1);
    if (wr_log8.size() == 1) check("p8_beat", wr_log8[0], {4'd10, 8'h0F});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
